// File: rtl/tipi_pkg.sv
// Shared constants and types for the TIPI mailbox RPi shift port.
// Address map, bit-counter width and the shift-state decode helper.
package tipi_pkg;

  localparam logic [15:0] TIPI_ADDR_TD = 16'h5FFF;
  localparam logic [15:0] TIPI_ADDR_TC = 16'h5FFD;
  localparam logic [15:0] TIPI_ADDR_RD = 16'h5FFB;
  localparam logic [15:0] TIPI_ADDR_RC = 16'h5FF9;

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FULL
  } shift_state_e;

  // The bit counter itself is the state: 0 idle, 1..7 shifting, 8 full.
  function automatic shift_state_e state_of(input logic [BIT_CNT_W-1:0] cnt);
    if (cnt == '0)
      return ST_IDLE;
    else if (cnt >= BIT_CNT_FULL)
      return ST_FULL;
    else
      return ST_SHIFT;
  endfunction

endpackage

// File: rtl/tipi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous RPi line, with a rising-edge
// pulse derived from the synchronized level.
module tipi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tipi_rpi_shift_port.sv
// RPi-facing TIPI shift port: deserializes RD/RC, serializes TD/TC, and serves
// TI reads of RD/RC. Optional idle timeout when TIPI_SHIFT_TIMEOUT_EN is defined.
module tipi_rpi_shift_port
  import tipi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_clk,
  input  logic        r_dout,
  input  logic        r_cd,
  input  logic        r_le,
  output logic        r_din,
  input  logic [7:0]  td_in,
  input  logic [7:0]  tc_in,
  input  logic [15:0] ti_a,
  input  logic        ti_memen,
  input  logic        ti_dbin,
  output logic [7:0]  ti_data_out,
  output logic        ti_data_oe,
  output logic [7:0]  rd_q,
  output logic [7:0]  rc_q,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  // Line order: 0 = r_clk, 1 = r_le, 2 = r_dout, 3 = r_cd.
  logic [3:0] async_vec;
  logic [3:0] level_vec;
  logic [3:0] rise_vec;

  assign async_vec = {r_cd, r_dout, r_le, r_clk};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      tipi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(async_vec[gi]),
        .level_o(level_vec[gi]),
        .rise_o (rise_vec[gi])
      );
    end
  endgenerate

  logic clk_rise, le_rise, dout_s, cd_s;
  assign clk_rise = rise_vec[0];
  assign le_rise  = rise_vec[1];
  assign dout_s   = level_vec[2];
  assign cd_s     = level_vec[3];

  logic unused_rise;
  assign unused_rise = ^rise_vec[3:2];

  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_in_q, shift_in_d;
  logic [7:0]           shift_out_q, shift_out_d;
  logic [7:0]           rd_d, rc_d, err_cnt_d;
  logic                 err_evt;
  shift_state_e         state;

`ifdef TIPI_SHIFT_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        timeout_hit;
  assign timeout_hit = (state != ST_IDLE) && (idle_cnt_q == TIMEOUT_LAST);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  assign state = state_of(bit_cnt_q);

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    rd_d        = rd_q;
    rc_d        = rc_q;
    err_evt     = 1'b0;

    if (le_rise) begin
      bit_cnt_d = '0;
      if (state == ST_FULL) begin
        if (cd_s)
          rc_d = shift_in_q;
        else
          rd_d = shift_in_q;
      end else begin
        err_evt = 1'b1;
      end
      // A simultaneous shift clock is dropped and flagged.
      if (clk_rise)
        err_evt = 1'b1;
    end else if (clk_rise) begin
      if (state != ST_FULL) begin
        shift_in_d  = {shift_in_q[6:0], dout_s};
        shift_out_d = {shift_out_q[6:0], 1'b0};
        bit_cnt_d   = bit_cnt_q + 1'b1;
      end else begin
        err_evt = 1'b1;
      end
    end else if (state == ST_IDLE) begin
      shift_out_d = cd_s ? tc_in : td_in;
    end
`ifdef TIPI_SHIFT_TIMEOUT_EN
    else if (timeout_hit) begin
      bit_cnt_d = '0;
      err_evt   = 1'b1;
    end
`endif

    err_cnt_d = (err_evt && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
  end

`ifdef TIPI_SHIFT_TIMEOUT_EN
  always_comb begin
    if (clk_rise || le_rise || bit_cnt_d == '0)
      idle_cnt_d = '0;
    else
      idle_cnt_d = idle_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt_q <= '0;
    else
      idle_cnt_q <= idle_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      rd_q        <= '0;
      rc_q        <= '0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      rd_q        <= rd_d;
      rc_q        <= rc_d;
      frame_err   <= err_evt;
      err_cnt     <= err_cnt_d;
    end
  end

  assign r_din = shift_out_q[7];

  // TI bus timing is unrelated to clk, so the read mux stays combinational.
  assign ti_data_oe  = ~ti_memen & ti_dbin &
                       ((ti_a == TIPI_ADDR_RD) | (ti_a == TIPI_ADDR_RC));
  assign ti_data_out = (ti_a == TIPI_ADDR_RC) ? rc_q : rd_q;

endmodule

// File: tb/tb_tipi_rpi_shift_port.sv
// Scoreboard bench for tipi_rpi_shift_port: randomized RPi frames and TI reads
// checked against a frame-level reference model.
module tb_tipi_rpi_shift_port;

  localparam int SYNC = 2;
  localparam int H    = SYNC + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_clk = 1'b0, r_dout = 1'b0, r_cd = 1'b0, r_le = 1'b0;
  logic        r_din;
  logic [7:0]  td_in = 8'h00, tc_in = 8'h00;
  logic [15:0] ti_a = 16'h0000;
  logic        ti_memen = 1'b1, ti_dbin = 1'b0;
  logic [7:0]  ti_data_out, rd_q, rc_q, err_cnt;
  logic        ti_data_oe, frame_err;

  tipi_rpi_shift_port #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .r_clk(r_clk), .r_dout(r_dout), .r_cd(r_cd),
    .r_le(r_le), .r_din(r_din), .td_in(td_in), .tc_in(tc_in), .ti_a(ti_a),
    .ti_memen(ti_memen), .ti_dbin(ti_dbin), .ti_data_out(ti_data_out),
    .ti_data_oe(ti_data_oe), .rd_q(rd_q), .rc_q(rc_q),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         kind;    // 0 frame/state, 1 TI read, 2 in-reset
    int         tag;
    logic [7:0] rd, rc, err, rdin_exp, rdin_obs, ti_out;
    bit         chk_rdin, ti_oe;
    int         pulses;
  } item_t;

  item_t exp_q[$];
  int checks = 0, errors = 0, items = 0;
  int obs_pulses = 0;

  logic [7:0] m_rd = 8'h00, m_rc = 8'h00;
  int         m_err = 0, m_pulses = 0;

  always @(posedge clk) if (frame_err === 1'b1) obs_pulses++;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (item %0d): got 0x%0h, expected 0x%0h", nm, tag, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented result and compares.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        if (it.kind == 1) begin
          chk("ti_data_oe", it.tag, 32'(ti_data_oe), 32'(it.ti_oe));
          if (it.ti_oe) chk("ti_data_out", it.tag, 32'(ti_data_out), 32'(it.ti_out));
        end else begin
          chk("rd_q", it.tag, 32'(rd_q), 32'(it.rd));
          chk("rc_q", it.tag, 32'(rc_q), 32'(it.rc));
          chk("err_cnt", it.tag, 32'(err_cnt), 32'(it.err));
          if (it.kind == 2) begin
            chk("r_din_rst", it.tag, 32'(r_din), 32'd0);
            chk("frame_err_rst", it.tag, 32'(frame_err), 32'd0);
          end else begin
            chk("frame_err_pulses", it.tag, 32'(obs_pulses), 32'(it.pulses));
          end
          if (it.chk_rdin) chk("rpi_read", it.tag, 32'(it.rdin_obs), 32'(it.rdin_exp));
        end
        $display("item %0d kind %0d checked: rd=%02h rc=%02h err_cnt=%0d oe=%0d", it.tag, it.kind, rd_q, rc_q, err_cnt, ti_data_oe);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void push_state(input int kind, input bit chk_rdin, input logic [7:0] rdin_exp, input logic [7:0] rdin_obs);
    item_t it;
    it.kind = kind; it.tag = items++;
    it.rd = m_rd; it.rc = m_rc; it.err = 8'(m_err);
    it.rdin_exp = rdin_exp; it.rdin_obs = rdin_obs; it.chk_rdin = chk_rdin;
    it.ti_out = 8'h00; it.ti_oe = 1'b0; it.pulses = m_pulses;
    exp_q.push_back(it);
  endfunction

  function automatic void model_errs(input int k);
    m_pulses += k;
    m_err = (m_err + k > 255) ? 255 : m_err + k;
  endfunction

  // Shift n bits (first 8 from data, MSB first), optionally followed by r_le.
  task automatic shift_bits(input int n, input bit cd, input logic [7:0] data,
                            input logic [7:0] td, input logic [7:0] tc, input bit do_le,
                            output logic [7:0] obs);
    r_cd = cd; td_in = td; tc_in = tc;
    obs = 8'h00;
    cyc(H);
    for (int i = 0; i < n; i++) begin
      r_dout = (i < 8) ? data[7-i] : 1'($urandom_range(0, 1));
      cyc(H);
      if (i < 8) obs[7-i] = r_din;
      r_clk = 1'b1;
      cyc(H);
      r_clk = 1'b0;
    end
    cyc(H);
    if (do_le) begin
      r_le = 1'b1;
      cyc(H);
      r_le = 1'b0;
      cyc(H);
    end
  endtask

  task automatic do_frame(input int n, input bit cd, input logic [7:0] data,
                          input logic [7:0] td, input logic [7:0] tc);
    logic [7:0] obs;
    shift_bits(n, cd, data, td, tc, 1'b1, obs);
    if (n < 8) begin
      model_errs(1);
    end else begin
      model_errs(n - 8);
      if (cd) m_rc = data; else m_rd = data;
    end
    push_state(0, n >= 8, cd ? tc : td, obs);
    cyc(2);
  endtask

  task automatic ti_read(input logic [15:0] a, input logic memen, input logic dbin);
    item_t it;
    ti_a = a; ti_memen = memen; ti_dbin = dbin;
    cyc(1);
    it.kind = 1; it.tag = items++;
    it.ti_oe = !memen && dbin && (a == 16'h5FFB || a == 16'h5FF9);
    it.ti_out = (a == 16'h5FF9) ? m_rc : m_rd;
    it.rd = 8'h00; it.rc = 8'h00; it.err = 8'h00; it.rdin_exp = 8'h00;
    it.rdin_obs = 8'h00; it.chk_rdin = 1'b0; it.pulses = 0;
    exp_q.push_back(it);
    cyc(2);
    ti_memen = 1'b1; ti_dbin = 1'b0;
  endtask

  initial begin
    logic [7:0] obs;
    logic [15:0] addrs [5];
    int lens [9];
    addrs = '{16'h5FFB, 16'h5FF9, 16'h5FFF, 16'h5FFD, 16'h0000};
    lens  = '{0, 3, 5, 7, 8, 8, 8, 9, 10};

    cyc(2);
    push_state(2, 1'b0, 8'h00, 8'h00);
    cyc(3);
    rst = 1'b0;
    cyc(3);

    do_frame(8, 1'b0, 8'hA5, 8'h11, 8'h22);
    do_frame(8, 1'b1, 8'h5A, 8'h3C, 8'hC3);
    ti_read(16'h5FF9, 1'b0, 1'b1);
    ti_read(16'h5FFB, 1'b0, 1'b1);
    ti_read(16'h5FFF, 1'b0, 1'b1);
    ti_read(16'h5FF9, 1'b1, 1'b1);
    do_frame(5, 1'b0, 8'hFF, 8'h00, 8'h00);
    do_frame(9, 1'b0, 8'h0F, 8'h96, 8'h00);

    shift_bits(4, 1'b0, 8'hF0, 8'h00, 8'h00, 1'b0, obs);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    m_rd = 8'h00; m_rc = 8'h00; m_err = 0;
    cyc(4);
    push_state(0, 1'b0, 8'h00, 8'h00);
    do_frame(8, 1'b0, 8'h81, 8'h42, 8'h24);

`ifdef TIPI_SHIFT_TIMEOUT_EN
    shift_bits(3, 1'b0, 8'hE0, 8'h00, 8'h00, 1'b0, obs);
    cyc(110);
    model_errs(1);
    push_state(0, 1'b0, 8'h00, 8'h00);
    do_frame(8, 1'b0, 8'h7E, 8'h00, 8'h00);
`endif

    for (int k = 0; k < 30; k++) begin
      do_frame(lens[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), 8'($urandom),
               8'($urandom), 8'($urandom));
      if (k % 3 == 0)
        ti_read(addrs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drive the error counter past saturation with bare latch pulses.
    for (int k = 0; k < 260; k++) begin
      r_le = 1'b1;
      cyc(H);
      r_le = 1'b0;
      cyc(H);
    end
    model_errs(260);
    cyc(2);
    push_state(0, 1'b0, 8'h00, 8'h00);
    do_frame(8, 1'b1, 8'hC7, 8'h00, 8'h99);
    ti_read(16'h5FF9, 1'b0, 1'b1);

    for (int k = 0; k < 200 && exp_q.size() > 0; k++) cyc(1);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d items unchecked, expected 0", exp_q.size());
    end
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
